// File: rtl/rv32_control_fsm_if.sv
// Fetch / data-memory handshake bundle for the RV32I control unit.
//   imem_req   : instruction fetch request (driven by the control unit)
//   imem_ack   : fetched instruction valid this cycle
//   imem_rdata : fetched instruction word
//   dmem_ack   : data access completes this cycle
// master = control unit side, slave = memory side.
interface rv32_control_fsm_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/rv32_control_fsm.sv
// Multi-cycle control unit for the RV32I core.
// Sequences each instruction through FETCH/DECODE/EXEC/(MEM)/WB and produces
// the control word, sign-extended immediate and register addresses consumed
// by pc_updater, ALU, register file and memory interface.
// Ports:
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : fetch/data handshake (master side)
//   cword    : 23-bit control word
//              [3:0] type [6:4] funct3 [7] funct7b5 [12:8] rd [13] reg_we
//              [14] mem_re [15] mem_we [16] alu_src_imm [17] pc_we
//              [19:18] wb_sel [20] br_eval [21] illegal [22] busy
//   imm      : decoded sign-extended immediate
//   rs1, rs2 : source register addresses
//   state    : current FSM state
module rv32_control_fsm #(
    parameter logic [31:0] RESET_IR = 32'h0000_0013,
    parameter int unsigned CWORD_W  = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    rv32_control_fsm_if.master        bus,
    output logic [CWORD_W-1:0]        cword,
    output logic [31:0]               imm,
    output logic [4:0]                rs1,
    output logic [4:0]                rs2,
    output logic [2:0]                state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        T_LOAD    = 4'd0,
        T_IMM     = 4'd1,
        T_STORE   = 4'd2,
        T_REG     = 4'd3,
        T_LUI     = 4'd4,
        T_AUIPC   = 4'd5,
        T_BRNCH   = 4'd6,
        T_JALR    = 4'd7,
        T_JAL     = 4'd8,
        T_ILLEGAL = 4'hF
    } inst_e;

    state_e      state_q;
    state_e      state_d;
    logic [31:0] ir;

    // Decoded fields, latched on DECODE exit and held until the next DECODE.
    inst_e       inst_type_q;
    logic [2:0]  funct3_q;
    logic        f7b5_q;
    logic [4:0]  rd_q;
    logic [31:0] imm_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic        illegal_q;

    // Combinational decode of the instruction register.
    inst_e       dec_type;
    logic [31:0] dec_imm;
    logic        dec_f7b5;

    // Strobes and per-state control.
    logic        imem_req;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        alu_src_imm;
    logic        pc_we;
    logic [1:0]  wb_sel;
    logic        br_eval;
    logic        busy;
    logic [22:0] cw;

    always_comb begin
        dec_type = T_ILLEGAL;
        unique case (ir[6:0])
            7'b0000011: dec_type = T_LOAD;
            7'b0010011: dec_type = T_IMM;
            7'b0100011: dec_type = T_STORE;
            7'b0110011: dec_type = T_REG;
            7'b0110111: dec_type = T_LUI;
            7'b0010111: dec_type = T_AUIPC;
            7'b1100011: dec_type = T_BRNCH;
            7'b1100111: dec_type = T_JALR;
            7'b1101111: dec_type = T_JAL;
            default:    dec_type = T_ILLEGAL;
        endcase
    end

    always_comb begin
        dec_imm = '0;
        case (dec_type)
            T_LOAD, T_IMM, T_JALR:
                dec_imm = {{20{ir[31]}}, ir[31:20]};
            T_STORE:
                dec_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            T_BRNCH:
                dec_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            T_LUI, T_AUIPC:
                dec_imm = {ir[31:12], 12'h000};
            T_JAL:
                dec_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:
                dec_imm = '0;
        endcase
    end

    // funct7[5] only distinguishes SUB/SRA (reg) and SRAI (imm, funct3=101).
    always_comb begin
        dec_f7b5 = 1'b0;
        if (dec_type == T_REG || (dec_type == T_IMM && ir[14:12] == 3'b101)) begin
            dec_f7b5 = ir[30];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            ir          <= RESET_IR;
            inst_type_q <= T_LOAD;
            funct3_q    <= '0;
            f7b5_q      <= 1'b0;
            rd_q        <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && bus.imem_ack) begin
                ir <= bus.imem_rdata;
            end
            if (state_q == S_DECODE) begin
                inst_type_q <= dec_type;
                funct3_q    <= ir[14:12];
                f7b5_q      <= dec_f7b5;
                rd_q        <= ir[11:7];
                imm_q       <= dec_imm;
                rs1_q       <= ir[19:15];
                rs2_q       <= ir[24:20];
                illegal_q   <= (dec_type == T_ILLEGAL);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        reg_we      = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        alu_src_imm = 1'b0;
        pc_we       = 1'b0;
        wb_sel      = 2'd0;
        br_eval     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (dec_type == T_ILLEGAL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                alu_src_imm = !(inst_type_q == T_REG || inst_type_q == T_BRNCH);
                br_eval     = (inst_type_q == T_BRNCH);
                state_d     = (inst_type_q == T_LOAD || inst_type_q == T_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_re = (inst_type_q == T_LOAD);
                mem_we = (inst_type_q == T_STORE);
                if (bus.dmem_ack) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_we  = 1'b1;
                reg_we = !(inst_type_q == T_STORE || inst_type_q == T_BRNCH) && (rd_q != 5'd0);
                if (inst_type_q == T_LOAD) begin
                    wb_sel = 2'd1;
                end else if (inst_type_q == T_JAL || inst_type_q == T_JALR) begin
                    wb_sel = 2'd2;
                end
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign busy = (state_q != S_FETCH);

    assign cw = {busy, illegal_q, br_eval, wb_sel, pc_we, alu_src_imm,
                 mem_we, mem_re, reg_we, rd_q, f7b5_q, funct3_q, inst_type_q};

    assign cword        = cw;
    assign imm          = imm_q;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;
    assign state        = state_q;
    assign bus.imem_req = imem_req;

endmodule

// File: tb/tb_rv32_control_fsm.sv
// Self-checking bench for rv32_control_fsm: directed plan instructions,
// randomized legal instructions with stray acks, illegal trap, and resets.
module tb_rv32_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] cword;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv32_control_fsm_if bus();

    rv32_control_fsm #(
        .RESET_IR(32'h0000_0013),
        .CWORD_W (23)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .cword(cword),
        .imm  (imm),
        .rs1  (rs1),
        .rs2  (rs2),
        .state(state)
    );

    // Reference view of one decoded instruction.
    typedef struct packed {
        logic [3:0]  typ;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
        logic        is_mem;
    } dec_t;

    dec_t prev_f;

    logic [2:0]  o_state [0:63];
    logic [22:0] o_cw    [0:63];
    logic [31:0] o_imm   [0:63];
    logic [4:0]  o_rs1   [0:63];
    logic [4:0]  o_rs2   [0:63];
    logic        o_req   [0:63];

    // Immediates are rebuilt arithmetically from field weights.
    function automatic dec_t model_decode(input logic [31:0] w);
        dec_t d;
        int   sw;
        int   sgn;
        d   = '0;
        sw  = $signed(w);
        sgn = sw >>> 31;
        d.rd  = w[11:7];
        d.f3  = w[14:12];
        d.rs1 = w[19:15];
        d.rs2 = w[24:20];
        case (w[6:0])
            7'b0000011: begin d.typ = 4'd0; d.imm = sw >>> 20; d.is_mem = 1'b1; end
            7'b0010011: begin d.typ = 4'd1; d.imm = sw >>> 20; end
            7'b0100011: begin
                d.typ = 4'd2; d.is_mem = 1'b1;
                d.imm = (sw >>> 25) * 32 + int'(w[11:7]);
            end
            7'b0110011: begin d.typ = 4'd3; d.imm = 32'd0; end
            7'b0110111: begin d.typ = 4'd4; d.imm = w & 32'hFFFF_F000; end
            7'b0010111: begin d.typ = 4'd5; d.imm = w & 32'hFFFF_F000; end
            7'b1100011: begin
                d.typ = 4'd6;
                d.imm = sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            end
            7'b1100111: begin d.typ = 4'd7; d.imm = sw >>> 20; end
            7'b1101111: begin
                d.typ = 4'd8;
                d.imm = sgn * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            end
            default: begin d.typ = 4'hF; d.illegal = 1'b1; d.imm = 32'd0; end
        endcase
        if (d.typ == 4'd3 || (d.typ == 4'd1 && d.f3 == 3'd5)) d.f7 = w[30];
        return d;
    endfunction

    // Expected state in cycle k given fetch wait fw and memory wait mw.
    function automatic int phase_at(input int k, input int fw, input int mw, input dec_t d);
        if (k <= fw) return 0;
        if (k == fw + 1) return 1;
        if (d.illegal) return 7;
        if (k == fw + 2) return 2;
        if (d.is_mem && k <= fw + 3 + mw) return 3;
        return 4;
    endfunction

    function automatic int n_cycles(input int fw, input int mw, input dec_t d);
        if (d.illegal) return fw + 6;
        return fw + 4 + (d.is_mem ? mw + 1 : 0);
    endfunction

    function automatic logic [22:0] exp_cword(input int ph, input dec_t f);
        logic [22:0] c;
        c = '0;
        c[3:0]  = f.typ;
        c[6:4]  = f.f3;
        c[7]    = f.f7;
        c[12:8] = f.rd;
        c[21]   = f.illegal;
        c[22]   = (ph != 0);
        if (ph == 2) begin
            c[16] = !(f.typ == 4'd3 || f.typ == 4'd6);
            c[20] = (f.typ == 4'd6);
        end
        if (ph == 3) begin
            c[14] = (f.typ == 4'd0);
            c[15] = (f.typ == 4'd2);
        end
        if (ph == 4) begin
            c[17]    = 1'b1;
            c[13]    = (f.typ != 4'd2 && f.typ != 4'd6 && f.rd != 5'd0);
            c[19:18] = (f.typ == 4'd0) ? 2'd1 : ((f.typ == 4'd7 || f.typ == 4'd8) ? 2'd2 : 2'd0);
        end
        return c;
    endfunction

    // Drives one instruction on a fixed ack schedule and records outputs per cycle.
    task automatic drive_instr(input logic [31:0] w, input int fw, input int mw,
                               input bit noise, input int ncyc, input bit is_mem);
        int ms;
        ms = fw + 3;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            o_state[k] = state;
            o_cw[k]    = cword;
            o_imm[k]   = imm;
            o_rs1[k]   = rs1;
            o_rs2[k]   = rs2;
            o_req[k]   = bus.imem_req;
            bus.imem_ack   = (k == fw);
            bus.imem_rdata = (k == fw) ? w : $urandom();
            bus.dmem_ack   = is_mem && (k == ms + mw);
            if (noise) begin
                if (k > fw && $urandom_range(0, 2) == 0) bus.imem_ack = 1'b1;
                if (!(is_mem && k >= ms && k <= ms + mw) && $urandom_range(0, 2) == 0)
                    bus.dmem_ack = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        bus.imem_ack   = 1'b0;
        bus.dmem_ack   = 1'b0;
        bus.imem_rdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        prev_f = '0;
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++;
        if (cword !== 23'd0) begin errors++; $display("FAIL reset_cword got=%h want=0", cword); end
        checks++;
        if (imm !== 32'd0 || rs1 !== 5'd0 || rs2 !== 5'd0) begin
            errors++; $display("FAIL reset_fields got imm=%h rs1=%0d rs2=%0d want 0", imm, rs1, rs2);
        end
        checks++;
        if (dut.ir !== 32'h0000_0013) begin errors++; $display("FAIL reset_ir got=%h want=00000013", dut.ir); end
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got=%b want=1", bus.imem_req); end
    endtask

    task automatic test_directed;
        logic [31:0] tw   [4] = '{32'h0050_0093, 32'h0080_A103, 32'h0020_A623, 32'hFFDF_F0EF};
        int          tfw  [4] = '{0, 1, 0, 2};
        int          tmw  [4] = '{0, 2, 1, 0};
        logic [31:0] timm [4] = '{32'd5, 32'd8, 32'd12, 32'hFFFF_FFFC};
        logic [3:0]  ttyp [4] = '{4'd1, 4'd0, 4'd2, 4'd8};
        int          tmrd [4] = '{0, 3, 0, 0};
        for (int t = 0; t < 4; t++) begin
            dec_t d, f;
            int n, ph, nre, npc;
            logic [22:0] ecw;
            d = model_decode(tw[t]);
            n = n_cycles(tfw[t], tmw[t], d);
            drive_instr(tw[t], tfw[t], tmw[t], 1'b0, n, d.is_mem);
            nre = 0; npc = 0;
            for (int k = 0; k < n; k++) begin
                ph  = phase_at(k, tfw[t], tmw[t], d);
                f   = (k <= tfw[t] + 1) ? prev_f : d;
                ecw = exp_cword(ph, f);
                nre += int'(o_cw[k][14]);
                npc += int'(o_cw[k][17]);
                checks++;
                if (o_state[k] !== 3'(ph)) begin errors++; $display("FAIL dir%0d_state k=%0d got=%0d want=%0d", t, k, o_state[k], ph); end
                checks++;
                if (o_cw[k] !== ecw) begin errors++; $display("FAIL dir%0d_cword k=%0d got=%h want=%h", t, k, o_cw[k], ecw); end
                checks++;
                if (o_req[k] !== (ph == 0)) begin errors++; $display("FAIL dir%0d_req k=%0d got=%b want=%b", t, k, o_req[k], ph == 0); end
                checks++;
                if (o_imm[k] !== f.imm || o_rs1[k] !== f.rs1 || o_rs2[k] !== f.rs2) begin
                    errors++;
                    $display("FAIL dir%0d_fields k=%0d got=%h/%0d/%0d want=%h/%0d/%0d", t, k,
                             o_imm[k], o_rs1[k], o_rs2[k], f.imm, f.rs1, f.rs2);
                end
            end
            checks++;
            if (o_imm[n-1] !== timm[t] || o_cw[n-1][3:0] !== ttyp[t]) begin
                errors++; $display("FAIL dir%0d_plan got imm=%h type=%0d want imm=%h type=%0d", t,
                                   o_imm[n-1], o_cw[n-1][3:0], timm[t], ttyp[t]);
            end
            checks++;
            if (nre !== tmrd[t]) begin errors++; $display("FAIL dir%0d_mem_re_cycles got=%0d want=%0d", t, nre, tmrd[t]); end
            checks++;
            if (npc !== 1) begin errors++; $display("FAIL dir%0d_pc_we_pulses got=%0d want=1", t, npc); end
            prev_f = d;
        end
    endtask

    task automatic test_random;
        logic [6:0] ops [9] = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011, 7'b0110111,
                                7'b0010111, 7'b1100011, 7'b1100111, 7'b1101111};
        for (int t = 0; t < 40; t++) begin
            logic [31:0] w, r;
            dec_t d, f;
            int fw, mw, n, ph;
            logic [22:0] ecw;
            r  = $urandom();
            w  = {r[31:7], ops[$urandom_range(0, 8)]};
            if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            d  = model_decode(w);
            n  = n_cycles(fw, mw, d);
            drive_instr(w, fw, mw, 1'b1, n, d.is_mem);
            for (int k = 0; k < n; k++) begin
                ph  = phase_at(k, fw, mw, d);
                f   = (k <= fw + 1) ? prev_f : d;
                ecw = exp_cword(ph, f);
                checks++;
                if (o_state[k] !== 3'(ph)) begin errors++; $display("FAIL rnd%0d_state w=%h k=%0d got=%0d want=%0d", t, w, k, o_state[k], ph); end
                checks++;
                if (o_cw[k] !== ecw) begin errors++; $display("FAIL rnd%0d_cword w=%h k=%0d got=%h want=%h", t, w, k, o_cw[k], ecw); end
                checks++;
                if (o_req[k] !== (ph == 0)) begin errors++; $display("FAIL rnd%0d_req k=%0d got=%b want=%b", t, k, o_req[k], ph == 0); end
                checks++;
                if (o_imm[k] !== f.imm || o_rs1[k] !== f.rs1 || o_rs2[k] !== f.rs2) begin
                    errors++;
                    $display("FAIL rnd%0d_fields w=%h k=%0d got=%h/%0d/%0d want=%h/%0d/%0d", t, w, k,
                             o_imm[k], o_rs1[k], o_rs2[k], f.imm, f.rs1, f.rs2);
                end
            end
            prev_f = d;
        end
    endtask

    task automatic test_reset_mid;
        // lw with no dmem_ack: cycle 0 FETCH(ack), 1 DECODE, 2 EXEC, 3 MEM.
        int npc;
        npc = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            npc += int'(cword[17]);
            bus.imem_ack   = (k == 0);
            bus.imem_rdata = 32'h0080_A103;
            bus.dmem_ack   = 1'b0;
        end
        checks++;
        if (state !== 3'd3 || cword[14] !== 1'b1) begin
            errors++; $display("FAIL mid_in_mem got state=%0d mem_re=%b want 3/1", state, cword[14]);
        end
        rst = 1'b1;
        @(negedge clk);
        npc += int'(cword[17]);
        checks++;
        if (state !== 3'd0 || cword !== 23'd0 || imm !== 32'd0) begin
            errors++; $display("FAIL mid_reset got state=%0d cword=%h imm=%h want 0/0/0", state, cword, imm);
        end
        checks++;
        if (dut.ir !== 32'h0000_0013) begin errors++; $display("FAIL mid_reset_ir got=%h want=00000013", dut.ir); end
        rst = 1'b0;
        prev_f = '0;
        @(negedge clk);
        npc += int'(cword[17]);
        checks++;
        if (state !== 3'd0 || bus.imem_req !== 1'b1) begin
            errors++; $display("FAIL mid_after got state=%0d req=%b want 0/1", state, bus.imem_req);
        end
        checks++;
        if (npc !== 0) begin errors++; $display("FAIL mid_pc_we got=%0d want=0", npc); end
    endtask

    task automatic test_ack_with_rst;
        @(negedge clk);
        rst            = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0050_0093;
        @(negedge clk);
        rst          = 1'b0;
        bus.imem_ack = 1'b0;
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL ackrst_state got=%0d want=0", state); end
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || dut.ir !== 32'h0000_0013) begin
            errors++; $display("FAIL ackrst_hold got state=%0d ir=%h want 0/00000013", state, dut.ir);
        end
        prev_f = '0;
    endtask

    task automatic test_illegal;
        // Compare type, illegal, busy and all strobes; funct3/rd are unspecified in TRAP.
        logic [22:0] mask;
        dec_t d, f;
        int n, ph;
        logic [22:0] ecw;
        mask = 23'h7F_E00F;
        d = model_decode(32'h0000_0000);
        n = n_cycles(1, 0, d);
        drive_instr(32'h0000_0000, 1, 0, 1'b1, n, 1'b0);
        for (int k = 0; k < n; k++) begin
            ph  = phase_at(k, 1, 0, d);
            f   = (k <= 2) ? prev_f : d;
            ecw = exp_cword(ph, f);
            checks++;
            if (o_state[k] !== 3'(ph)) begin errors++; $display("FAIL ill_state k=%0d got=%0d want=%0d", k, o_state[k], ph); end
            checks++;
            if ((o_cw[k] & mask) !== (ecw & mask)) begin
                errors++; $display("FAIL ill_cword k=%0d got=%h want=%h", k, o_cw[k] & mask, ecw & mask);
            end
            checks++;
            if (o_req[k] !== (ph == 0)) begin errors++; $display("FAIL ill_req k=%0d got=%b want=%b", k, o_req[k], ph == 0); end
        end
        @(negedge clk);
        bus.imem_ack = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        checks++;
        if (state !== 3'd0 || cword !== 23'd0) begin
            errors++; $display("FAIL ill_reset got state=%0d cword=%h want 0/0", state, cword);
        end
        prev_f = '0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_reset_mid;
        test_ack_with_rst;
        test_directed;
        test_illegal;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32_control_fsm.md
Name: rv32_control_fsm

Overview:
- Multi-cycle control unit for the RV32I core.
- Produces the 23-bit control word `cword`, the sign-extended immediate `imm` and the register addresses that `pc_updater`, the ALU, the register file and the memory interface consume.
- Drives the fetch handshake, sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, and issues a single `pc_we` strobe per instruction so `pc_updater` advances exactly once.

Parameters:
- RESET_IR, 32'h0000_0013, instruction register value after reset (`addi x0,x0,0`).
- CWORD_W, 23, control word width; fixed layout below, any other value is unsupported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- dmem_ack  in  1  data access complete this cycle
- cword  out  23  control word
- imm  out  32  decoded sign-extended immediate
- rs1  out  5  source register 1 address
- rs2  out  5  source register 2 address
- state  out  3  current FSM state (debug/verification)

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - state=FETCH(0); ir=RESET_IR; cword=0; imm=0; rs1=rs2=0.
  - imem_req=1 in the first cycle after reset deasserts.
  - Reset mid-operation abandons the instruction: no `pc_we` or `reg_we` pulse on or after the reset edge.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- cword layout:
  - [3:0] instType: load 0, imm 1, store 2, reg 3, lui 4, auipc 5, brnch 6, jalr 7, jal 8, illegal 4'hF.
  - [6:4] funct3; [7] funct7[5], only meaningful for reg, and for imm with funct3=101.
  - [12:8] rd; [13] reg_we; [14] mem_re; [15] mem_we; [16] alu_src_imm; [17] pc_we.
  - [19:18] wb_sel: 0 ALU, 1 mem, 2 pc+4.
  - [20] br_eval; [21] illegal; [22] busy, which is 1 in every state except FETCH.
- Opcode decode, `ir[6:0]`:
  - 0000011 load, 0010011 imm, 0100011 store, 0110011 reg, 0110111 lui, 0010111 auipc, 1100011 brnch, 1100111 jalr, 1101111 jal.
  - Any other opcode is illegal.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir<=imem_rdata, go to DECODE. Otherwise hold; there is no timeout.
  - imem_req deasserts the cycle after ack.
- DECODE (1 cycle):
  - Registers instType, funct3, funct7b5, rd, rs1=ir[19:15], rs2=ir[24:20] and imm.
  - imm formats: I for load/imm/jalr; S for store; B for brnch; U (ir[31:12]<<12) for lui/auipc; J for jal; 0 for reg.
  - Illegal opcode: instType=F, illegal=1, go to TRAP. Otherwise go to EXEC.
- EXEC (1 cycle):
  - alu_src_imm=1 for every type except reg and brnch.
  - br_eval=1 for brnch.
  - load/store go to MEM; all others go to WB.
- MEM:
  - mem_re=1 (load) or mem_we=1 (store), held until dmem_ack.
  - Go to WB in the cycle after ack.
- WB (1 cycle):
  - pc_we=1.
  - reg_we=1 unless the type is store or brnch, or rd=0.
  - wb_sel: 1 for load, 2 for jal/jalr, else 0.
  - Next state FETCH.
- Pulse rule: pc_we, reg_we, mem_re, mem_we and br_eval are 0 outside their listed states.
- Field stability: instType, imm, rd, rs1 and rs2 hold stable from DECODE exit until the next DECODE.
- TRAP:
  - Sticky until rst.
  - cword keeps illegal=1 and instType=F; all strobes 0; imem_req=0.
- Timing: with imem_ack in the first FETCH cycle, a non-memory instruction takes 4 cycles.
- Boundary conditions:
  - imem_ack outside FETCH and dmem_ack outside MEM are ignored.
  - imem_ack coincident with rst: reset wins.

Test Plan:
- `addi x1,x0,5` (0x00500093), imem_ack immediate:
  - states 0,1,2,4; instType=1, imm=5, rd=1, alu_src_imm=1.
  - pc_we=1 and reg_we=1 in cycle 4 only; FETCH again in cycle 5.
- `lw x2,8(x1)` (0x0080A103), dmem_ack after 3 MEM cycles:
  - instType=0, imm=8, rs1=1, rd=2.
  - mem_re high for exactly 3 cycles; WB with wb_sel=1 and reg_we=1.
- `sw x2,12(x1)` (0x0020A623):
  - instType=2, imm=12, rs2=2; mem_we held until ack.
  - In WB, reg_we=0 and pc_we=1.
- `jal x1,-4` (0xFFDFF0EF):
  - instType=8, imm=32'hFFFF_FFFC, rd=1.
  - No MEM state; WB with wb_sel=2, reg_we=1, pc_we=1.
- Illegal instruction 0x00000000:
  - DECODE goes to TRAP (state=7) with cword[21]=1 and instType=F.
  - Further imem_ack pulses are ignored; rst returns to FETCH with cword=0.
- Reset mid-instruction:
  - Assert rst while in MEM with mem_re=1.
  - Next cycle: state=0, all strobes 0, ir=RESET_IR, and no pc_we pulse appears.
